n1_dsp_agu: RTL and testbench

//  Parametrised stack address-generation unit for the N1 DSP partition; generalises the fixed
//  IPS/IRS AGU pair to CH independent channels, each growing up or down.

---
 rtl/n1_dsp_agu.sv | 93 +++++++++
 tb/tb_n1_dsp_agu.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/n1_dsp_agu.sv
// rtl/n1_dsp_agu.sv - CH-channel up/down stack address generator with full/empty and sticky ovf/unf flags
// Optional high-water mark per channel when N1_AGU_HWM_EN is defined.
module n1_dsp_agu #(
    parameter int              SP_WIDTH = 12,
    parameter int              CH       = 2,
    parameter logic [CH-1:0]   GROW_UP  = 2'b10
) (
    input  logic                   clk_i,
    input  logic                   async_rst_i,
    input  logic [CH-1:0]          agu_psh_i,
    input  logic [CH-1:0]          agu_pul_i,
    input  logic [CH-1:0]          agu_rst_i,
    output logic [CH*SP_WIDTH-1:0] agu_lsp_o,
    output logic [CH*SP_WIDTH-1:0] agu_lvl_o,
    output logic [CH-1:0]          agu_empty_o,
    output logic [CH-1:0]          agu_full_o,
    output logic [CH-1:0]          agu_ovf_o,
    output logic [CH-1:0]          agu_unf_o,
    output logic [CH*SP_WIDTH-1:0] agu_hwm_o
);

    localparam logic [SP_WIDTH-1:0] LVL_MAX = '1;
    localparam logic [SP_WIDTH-1:0] LVL_ONE = SP_WIDTH'(1);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [SP_WIDTH-1:0] lvl_q, lvl_d;
        logic                ovf_q, ovf_d;
        logic                unf_q, unf_d;
        logic                full, empty;

        assign full  = (lvl_q == LVL_MAX);
        assign empty = (lvl_q == '0);

        // Simultaneous push and pull replaces the top entry, so depth and flags stay put.
        always_comb begin
            lvl_d = lvl_q;
            ovf_d = ovf_q;
            unf_d = unf_q;
            if (agu_rst_i[i]) begin
                lvl_d = '0;
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end else if (agu_psh_i[i] && agu_pul_i[i]) begin
                lvl_d = lvl_q;
            end else if (agu_psh_i[i]) begin
                if (full) ovf_d = 1'b1;
                else      lvl_d = lvl_q + LVL_ONE;
            end else if (agu_pul_i[i]) begin
                if (empty) unf_d = 1'b1;
                else       lvl_d = lvl_q - LVL_ONE;
            end
        end

        always_ff @(posedge clk_i or negedge async_rst_i) begin
            if (!async_rst_i) begin
                lvl_q <= '0;
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end else begin
                lvl_q <= lvl_d;
                ovf_q <= ovf_d;
                unf_q <= unf_d;
            end
        end

        assign agu_lsp_o[i*SP_WIDTH +: SP_WIDTH] = GROW_UP[i] ? lvl_q : ~lvl_q;
        assign agu_lvl_o[i*SP_WIDTH +: SP_WIDTH] = lvl_q;
        assign agu_empty_o[i]                    = empty;
        assign agu_full_o[i]                     = full;
        assign agu_ovf_o[i]                      = ovf_q;
        assign agu_unf_o[i]                      = unf_q;

`ifdef N1_AGU_HWM_EN
        logic [SP_WIDTH-1:0] hwm_q, hwm_d;

        always_comb begin
            hwm_d = hwm_q;
            if (agu_rst_i[i])        hwm_d = '0;
            else if (lvl_d > hwm_q)  hwm_d = lvl_d;
        end

        always_ff @(posedge clk_i or negedge async_rst_i) begin
            if (!async_rst_i) hwm_q <= '0;
            else              hwm_q <= hwm_d;
        end

        assign agu_hwm_o[i*SP_WIDTH +: SP_WIDTH] = hwm_q;
`else
        assign agu_hwm_o[i*SP_WIDTH +: SP_WIDTH] = '0;
`endif
    end

endmodule

// File: tb/tb_n1_dsp_agu.sv
// tb/tb_n1_dsp_agu.sv - directed scoreboard bench for n1_dsp_agu (SP_WIDTH=4, CH=2, ch1 up, ch0 down)
module tb_n1_dsp_agu;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] psh, pul, crst;
    logic [7:0] lsp, lvl, hwm;
    logic [1:0] empty, full, ovf, unf;

    n1_dsp_agu #(.SP_WIDTH(4), .CH(2), .GROW_UP(2'b10)) dut (
        .clk_i       (clk),
        .async_rst_i (rst_n),
        .agu_psh_i   (psh),
        .agu_pul_i   (pul),
        .agu_rst_i   (crst),
        .agu_lsp_o   (lsp),
        .agu_lvl_o   (lvl),
        .agu_empty_o (empty),
        .agu_full_o  (full),
        .agu_ovf_o   (ovf),
        .agu_unf_o   (unf),
        .agu_hwm_o   (hwm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] lsp, lvl, hwm;
        logic [1:0] empty, full, ovf, unf;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    int   m_lvl[2];
    bit   m_ovf[2], m_unf[2];
    int   m_hwm[2];

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            m_lvl[c] = 0; m_ovf[c] = 0; m_unf[c] = 0; m_hwm[c] = 0;
        end
    endfunction

    function automatic void model_apply(logic [1:0] p, logic [1:0] q, logic [1:0] r);
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int c = 0; c < 2; c++) begin
            if (r[c]) begin
                m_lvl[c] = 0; m_ovf[c] = 0; m_unf[c] = 0; m_hwm[c] = 0;
            end else if (p[c] && q[c]) begin
                m_lvl[c] = m_lvl[c];
            end else if (p[c]) begin
                if (m_lvl[c] == 15) m_ovf[c] = 1; else m_lvl[c]++;
            end else if (q[c]) begin
                if (m_lvl[c] == 0) m_unf[c] = 1; else m_lvl[c]--;
            end
            if (!r[c] && m_lvl[c] > m_hwm[c]) m_hwm[c] = m_lvl[c];
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.lsp   = {4'(m_lvl[1]), 4'(15 - m_lvl[0])};
        e.lvl   = {4'(m_lvl[1]), 4'(m_lvl[0])};
        e.empty = {m_lvl[1] == 0, m_lvl[0] == 0};
        e.full  = {m_lvl[1] == 15, m_lvl[0] == 15};
        e.ovf   = {m_ovf[1], m_ovf[0]};
        e.unf   = {m_unf[1], m_unf[0]};
`ifdef N1_AGU_HWM_EN
        e.hwm   = {4'(m_hwm[1]), 4'(m_hwm[0])};
`else
        e.hwm   = 8'h00;
`endif
        return e;
    endfunction

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic compare_pop(string tag);
        exp_t e;
        e = sb.pop_front();
        chk({tag, ".lsp"},   lsp,          e.lsp);
        chk({tag, ".lvl"},   lvl,          e.lvl);
        chk({tag, ".empty"}, {6'b0, empty}, {6'b0, e.empty});
        chk({tag, ".full"},  {6'b0, full},  {6'b0, e.full});
        chk({tag, ".ovf"},   {6'b0, ovf},   {6'b0, e.ovf});
        chk({tag, ".unf"},   {6'b0, unf},   {6'b0, e.unf});
        chk({tag, ".hwm"},   hwm,          e.hwm);
    endtask

    task automatic step(string tag, logic [1:0] p, logic [1:0] q, logic [1:0] r);
        psh = p; pul = q; crst = r;
        model_apply(p, q, r);
        sb.push_back(model_out());
        @(posedge clk);
        #1;
        compare_pop(tag);
    endtask

    initial begin
        rst_n = 1'b0; psh = '0; pul = '0; crst = '0;
        model_reset();

        // Reset state before any clock edge.
        #2;
        chk("rst.lsp_const", lsp, 8'h0F);
        chk("rst.empty_const", {6'b0, empty}, 8'h03);
        sb.push_back(model_out());
        compare_pop("rst");

        @(negedge clk); rst_n = 1'b1;

        for (int k = 0; k < 3; k++) step("par_push", 2'b11, 2'b00, 2'b00);
        chk("par_push.lsp_const", lsp, 8'h3C);
        chk("par_push.lvl_const", lvl, 8'h33);

        for (int k = 0; k < 12; k++) step("ch1_fill", 2'b10, 2'b00, 2'b00);
        chk("ch1_full_const", {6'b0, full}, 8'h02);
        step("ch1_ovf", 2'b10, 2'b00, 2'b00);
        chk("ch1_ovf_lsp_const", lsp[7:4], 8'h0F);
        chk("ch1_ovf_const", {6'b0, ovf}, 8'h02);
        step("ch1_pull_a", 2'b00, 2'b10, 2'b00);
        step("ch1_pull_b", 2'b00, 2'b10, 2'b00);
        chk("ch1_ovf_sticky_const", {6'b0, ovf}, 8'h02);
        step("ch1_rst", 2'b00, 2'b00, 2'b10);
        chk("ch1_rst_lsp_const", lsp[7:4], 8'h00);

        for (int k = 0; k < 4; k++) step("ch0_drain", 2'b00, 2'b01, 2'b00);
        chk("ch0_unf_const", {6'b0, unf}, 8'h01);
        chk("ch0_unf_lsp_const", lsp[3:0], 8'h0F);
        for (int k = 0; k < 5; k++) step("ch0_fill5", 2'b01, 2'b00, 2'b00);
        step("ch0_pshpul", 2'b01, 2'b01, 2'b00);
        chk("ch0_pshpul_lvl_const", lvl[3:0], 8'h05);
        step("ch0_rst_psh", 2'b01, 2'b00, 2'b01);
        chk("ch0_rst_psh_lvl_const", lvl[3:0], 8'h00);

        for (int k = 0; k < 9; k++) step("hwm_up", 2'b10, 2'b00, 2'b00);
        for (int k = 0; k < 7; k++) step("hwm_down", 2'b00, 2'b10, 2'b00);
        chk("hwm_lvl1_const", lvl[7:4], 8'h02);
`ifdef N1_AGU_HWM_EN
        chk("hwm1_const", hwm[7:4], 8'h09);
`else
        chk("hwm1_zero_const", hwm, 8'h00);
`endif
        step("hwm_rst", 2'b00, 2'b00, 2'b10);
        chk("hwm_rst_const", hwm[7:4], 8'h00);

        for (int k = 0; k < 7; k++) step("ch1_to7", 2'b10, 2'b00, 2'b00);
        chk("ch1_lvl7_const", lvl[7:4], 8'h07);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_mid.lsp_const", lsp, 8'h0F);
        sb.push_back(model_out());
        compare_pop("async_mid");
        step("psh_in_rst_a", 2'b11, 2'b00, 2'b00);
        step("psh_in_rst_b", 2'b11, 2'b00, 2'b00);
        @(negedge clk); rst_n = 1'b1;
        step("post_rst_idle", 2'b00, 2'b00, 2'b00);
        step("post_rst_push", 2'b10, 2'b00, 2'b00);
        chk("post_rst_lsp_const", lsp, 8'h1F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
